// File: rtl/writeback_sequencer.sv
// -----------------------------------------------------------------------------
// writeback_sequencer
//
// Write-side companion of the SIMD register file. It accepts results from the
// ALU and from the memory load path and buffers each source in its own FIFO.
// One head entry per cycle goes onto the register file's single write port.
// It also publishes per-register pending-write bitmaps so that decode can stall
// on RAW hazards.
//
// Handshake: a source entry transfers on a rising clock edge where xValid and
// xReady are both high. xReady depends only on the registered FIFO count, so a
// pop in the same cycle never frees a slot for a push into a full FIFO. While
// xReady is low the producer must hold xValid/xIsVec/xDest/xData stable.
//
// Ports
//   clk, reset              single clock, synchronous active-high reset
//   aluValid/aluReady       ALU result handshake
//   aluIsVec, aluDest       destination kind (1 = vector) and register index
//   aluData                 result; scalar results use element 0
//   memValid/memReady       load-path handshake
//   memIsVec, memDest       destination kind and register index
//   memData                 load data
//   stall                   no FIFO pop while high
//   regWrEnSc, regWrEnVec   register-file write enables (one-cycle pulses)
//   regToWrite, dataIn      register-file write destination and data
//   pendingSc, pendingVec   bit i = a write to that register is queued or
//                           presenting
// -----------------------------------------------------------------------------
module writeback_sequencer #(
    parameter int registerSize  = 32,
    parameter int vecSize       = 4,
    parameter int selectionBits = 2,
    parameter int fifoDepth     = 4
) (
    input  logic                              clk,
    input  logic                              reset,

    input  logic                              aluValid,
    output logic                              aluReady,
    input  logic                              aluIsVec,
    input  logic [selectionBits-1:0]          aluDest,
    input  logic [vecSize*registerSize-1:0]   aluData,

    input  logic                              memValid,
    output logic                              memReady,
    input  logic                              memIsVec,
    input  logic [selectionBits-1:0]          memDest,
    input  logic [vecSize*registerSize-1:0]   memData,

    input  logic                              stall,

    output logic                              regWrEnSc,
    output logic                              regWrEnVec,
    output logic [selectionBits-1:0]          regToWrite,
    output logic [vecSize*registerSize-1:0]   dataIn,

    output logic [(2**selectionBits)-1:0]     pendingSc,
    output logic [(2**selectionBits)-1:0]     pendingVec
);

    localparam int DW = vecSize * registerSize;
    localparam int PW = $clog2(fifoDepth);
    localparam int CW = PW + 1;

    // Keeps only element 0; used to zero-fill scalar writes.
    localparam logic [DW-1:0] ELEM0_MASK = DW'({registerSize{1'b1}});

    // -------------------------------------------------------------------------
    // FIFO storage and pointers
    // -------------------------------------------------------------------------
    logic              r_alu_vec  [fifoDepth];
    logic [selectionBits-1:0] r_alu_dest [fifoDepth];
    logic [DW-1:0]     r_alu_data [fifoDepth];
    logic [PW-1:0]     r_alu_rd;
    logic [PW-1:0]     r_alu_wr;
    logic [CW-1:0]     r_alu_cnt;

    logic              r_mem_vec  [fifoDepth];
    logic [selectionBits-1:0] r_mem_dest [fifoDepth];
    logic [DW-1:0]     r_mem_data [fifoDepth];
    logic [PW-1:0]     r_mem_rd;
    logic [PW-1:0]     r_mem_wr;
    logic [CW-1:0]     r_mem_cnt;

    // 1 = memory won the most recent pop; resets to ALU so the first tie goes
    // to memory.
    logic              r_last_mem;

    // Output register driving the register file.
    logic              r_wr_en_sc;
    logic              r_wr_en_vec;
    logic [selectionBits-1:0] r_wr_dest;
    logic [DW-1:0]     r_wr_data;

    // -------------------------------------------------------------------------
    // Handshake and arbitration
    // -------------------------------------------------------------------------
    logic              w_alu_push;
    logic              w_mem_push;
    logic              w_alu_nonempty;
    logic              w_mem_nonempty;
    logic              w_pop_any;
    logic              w_grant_mem;
    logic              w_alu_pop;
    logic              w_mem_pop;
    logic              w_head_vec;
    logic [selectionBits-1:0] w_head_dest;
    logic [DW-1:0]     w_head_data;
    logic [DW-1:0]     w_head_fill;

    // Ready is forced low while reset is asserted; otherwise it only looks at
    // the registered count.
    assign aluReady = !reset && (r_alu_cnt < CW'(fifoDepth));
    assign memReady = !reset && (r_mem_cnt < CW'(fifoDepth));

    assign w_alu_push = aluValid && aluReady;
    assign w_mem_push = memValid && memReady;

    assign w_alu_nonempty = (r_alu_cnt != '0);
    assign w_mem_nonempty = (r_mem_cnt != '0);

    assign w_pop_any   = !stall && (w_alu_nonempty || w_mem_nonempty);
    // Memory wins when it is the only candidate, or on a tie when the ALU
    // took the previous grant.
    assign w_grant_mem = w_mem_nonempty && (!w_alu_nonempty || !r_last_mem);
    assign w_alu_pop   = w_pop_any && !w_grant_mem;
    assign w_mem_pop   = w_pop_any &&  w_grant_mem;

    always_comb begin
        w_head_vec  = r_alu_vec[r_alu_rd];
        w_head_dest = r_alu_dest[r_alu_rd];
        w_head_data = r_alu_data[r_alu_rd];
        if (w_grant_mem) begin
            w_head_vec  = r_mem_vec[r_mem_rd];
            w_head_dest = r_mem_dest[r_mem_rd];
            w_head_data = r_mem_data[r_mem_rd];
        end
    end

    assign w_head_fill = w_head_vec ? w_head_data : (w_head_data & ELEM0_MASK);

    // -------------------------------------------------------------------------
    // FIFO payload storage (no reset needed; validity comes from the count)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_alu_push) begin
            r_alu_vec[r_alu_wr]  <= aluIsVec;
            r_alu_dest[r_alu_wr] <= aluDest;
            r_alu_data[r_alu_wr] <= aluData;
        end
        if (w_mem_push) begin
            r_mem_vec[r_mem_wr]  <= memIsVec;
            r_mem_dest[r_mem_wr] <= memDest;
            r_mem_data[r_mem_wr] <= memData;
        end
    end

    // -------------------------------------------------------------------------
    // ALU FIFO pointers and count
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_alu_rd  <= '0;
            r_alu_wr  <= '0;
            r_alu_cnt <= '0;
        end else begin
            if (w_alu_push) r_alu_wr <= r_alu_wr + 1'b1;
            if (w_alu_pop)  r_alu_rd <= r_alu_rd + 1'b1;
            case ({w_alu_push, w_alu_pop})
                2'b10:   r_alu_cnt <= r_alu_cnt + 1'b1;
                2'b01:   r_alu_cnt <= r_alu_cnt - 1'b1;
                default: r_alu_cnt <= r_alu_cnt;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Memory FIFO pointers and count
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_rd  <= '0;
            r_mem_wr  <= '0;
            r_mem_cnt <= '0;
        end else begin
            if (w_mem_push) r_mem_wr <= r_mem_wr + 1'b1;
            if (w_mem_pop)  r_mem_rd <= r_mem_rd + 1'b1;
            case ({w_mem_push, w_mem_pop})
                2'b10:   r_mem_cnt <= r_mem_cnt + 1'b1;
                2'b01:   r_mem_cnt <= r_mem_cnt - 1'b1;
                default: r_mem_cnt <= r_mem_cnt;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output register and round-robin state
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_mem  <= 1'b0;
            r_wr_en_sc  <= 1'b0;
            r_wr_en_vec <= 1'b0;
            r_wr_dest   <= '0;
            r_wr_data   <= '0;
        end else if (w_pop_any) begin
            r_last_mem  <= w_grant_mem;
            r_wr_en_sc  <= !w_head_vec;
            r_wr_en_vec <= w_head_vec;
            r_wr_dest   <= w_head_dest;
            r_wr_data   <= w_head_fill;
        end else begin
            // Idle cycles present all-zero so stale data never looks valid.
            r_wr_en_sc  <= 1'b0;
            r_wr_en_vec <= 1'b0;
            r_wr_dest   <= '0;
            r_wr_data   <= '0;
        end
    end

    assign regWrEnSc  = r_wr_en_sc;
    assign regWrEnVec = r_wr_en_vec;
    assign regToWrite = r_wr_dest;
    assign dataIn     = r_wr_data;

    // -------------------------------------------------------------------------
    // Pending-write bitmaps
    // -------------------------------------------------------------------------
    // A slot is live when its distance from the read pointer (mod depth) is
    // below the count; pointers wrap naturally since the depth is a power of 2.
    function automatic logic slot_live(input logic [PW-1:0] idx,
                                       input logic [PW-1:0] rd,
                                       input logic [CW-1:0] cnt);
        logic [PW-1:0] off;
        off = idx - rd;
        return ({1'b0, off} < cnt);
    endfunction

    always_comb begin
        pendingSc  = '0;
        pendingVec = '0;
        for (int i = 0; i < fifoDepth; i++) begin
            if (slot_live(PW'(i), r_alu_rd, r_alu_cnt)) begin
                if (r_alu_vec[i]) pendingVec[r_alu_dest[i]] = 1'b1;
                else              pendingSc[r_alu_dest[i]]  = 1'b1;
            end
            if (slot_live(PW'(i), r_mem_rd, r_mem_cnt)) begin
                if (r_mem_vec[i]) pendingVec[r_mem_dest[i]] = 1'b1;
                else              pendingSc[r_mem_dest[i]]  = 1'b1;
            end
        end
        // The write presenting this cycle still counts until the register
        // file captures it at the end of the cycle.
        if (r_wr_en_vec) pendingVec[r_wr_dest] = 1'b1;
        if (r_wr_en_sc)  pendingSc[r_wr_dest]  = 1'b1;
    end

endmodule
